// File: rtl/riscv_memarb.sv
// rtl/riscv_memarb.sv - shared single-port memory arbiter for fetch and MEM-stage data
//
// Purpose: serialises instruction fetch (32-bit, read-only) and data access
// (64-bit, read/write) onto one memory with a variable-latency req/ack
// handshake, and reports per-stage stalls to the hazard unit.
// Optional build macro: RISCV_MEMARB_RR_EN (round-robin arbitration when both
// requesters are pending; default is fixed data-over-fetch priority).
//
// Ports:
//   i_riscv_memarb_clk / i_riscv_memarb_rst    clock, async active-low reset
//   i_riscv_memarb_if_*                        fetch request / address
//   o_riscv_memarb_if_inst / _if_valid         fetched instruction, 1-cycle valid
//   i_riscv_memarb_dm_*                        data request, wen, sel, addr, wdata
//   o_riscv_memarb_dm_rdata / _dm_valid        load data, 1-cycle completion
//   o_riscv_memarb_mem_* / i_riscv_memarb_mem_* memory req/ack interface
//   o_riscv_memarb_stall_if / _stall_m         stalls to hazard unit

module riscv_memarb #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              i_riscv_memarb_clk,
    input  logic              i_riscv_memarb_rst,
    input  logic              i_riscv_memarb_if_req,
    input  logic [ADDR_W-1:0] i_riscv_memarb_if_addr,
    output logic [31:0]       o_riscv_memarb_if_inst,
    output logic              o_riscv_memarb_if_valid,
    input  logic              i_riscv_memarb_dm_req,
    input  logic              i_riscv_memarb_dm_wen,
    input  logic [1:0]        i_riscv_memarb_dm_sel,
    input  logic [ADDR_W-1:0] i_riscv_memarb_dm_addr,
    input  logic [DATA_W-1:0] i_riscv_memarb_dm_wdata,
    output logic [DATA_W-1:0] o_riscv_memarb_dm_rdata,
    output logic              o_riscv_memarb_dm_valid,
    output logic              o_riscv_memarb_mem_req,
    output logic              o_riscv_memarb_mem_wen,
    output logic [1:0]        o_riscv_memarb_mem_sel,
    output logic [ADDR_W-1:0] o_riscv_memarb_mem_addr,
    output logic [DATA_W-1:0] o_riscv_memarb_mem_wdata,
    input  logic              i_riscv_memarb_mem_ack,
    input  logic [DATA_W-1:0] i_riscv_memarb_mem_rdata,
    output logic              o_riscv_memarb_stall_if,
    output logic              o_riscv_memarb_stall_m
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                grant_dm_q, grant_dm_d;   // 1 = data owns the access
    logic                live_q, live_d;           // requester still wants the result
    logic                wen_q, wen_d;
    logic [1:0]          sel_q, sel_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                pick_dm;
    logic                cur_req;

`ifdef RISCV_MEMARB_RR_EN
    // 0 = fetch was granted last, 1 = data was granted last
    logic                last_grant_q, last_grant_d;

    // Data wins a tie only when fetch had the previous grant.
    assign pick_dm = i_riscv_memarb_dm_req & (~i_riscv_memarb_if_req | ~last_grant_q);
`else
    assign pick_dm = i_riscv_memarb_dm_req;
`endif

    assign cur_req = grant_dm_q ? i_riscv_memarb_dm_req : i_riscv_memarb_if_req;

    always_comb begin
        state_d    = state_q;
        grant_dm_d = grant_dm_q;
        live_d     = live_q;
        wen_d      = wen_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
`ifdef RISCV_MEMARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_dm) begin
                    state_d    = DM_BUSY;
                    grant_dm_d = 1'b1;
                    live_d     = 1'b1;
                    wen_d      = i_riscv_memarb_dm_wen;
                    sel_d      = i_riscv_memarb_dm_sel;
                    addr_d     = i_riscv_memarb_dm_addr;
                    wdata_d    = i_riscv_memarb_dm_wdata;
`ifdef RISCV_MEMARB_RR_EN
                    last_grant_d = 1'b1;
`endif
                end else if (i_riscv_memarb_if_req) begin
                    state_d    = IF_BUSY;
                    grant_dm_d = 1'b0;
                    live_d     = 1'b1;
                    wen_d      = 1'b0;
                    sel_d      = 2'b11;
                    addr_d     = i_riscv_memarb_if_addr;
                    wdata_d    = '0;
`ifdef RISCV_MEMARB_RR_EN
                    last_grant_d = 1'b0;
`endif
                end
            end
            IF_BUSY, DM_BUSY: begin
                // A withdrawn request (e.g. fetch flushed by a branch) still
                // lets the memory finish; only the valid pulse is dropped.
                if (!cur_req) begin
                    live_d = 1'b0;
                end
                if (i_riscv_memarb_mem_ack) begin
                    rdata_d = i_riscv_memarb_mem_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_riscv_memarb_clk or negedge i_riscv_memarb_rst) begin
        if (!i_riscv_memarb_rst) begin
            state_q    <= IDLE;
            grant_dm_q <= 1'b0;
            live_q     <= 1'b0;
            wen_q      <= 1'b0;
            sel_q      <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
`ifdef RISCV_MEMARB_RR_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            grant_dm_q <= grant_dm_d;
            live_q     <= live_d;
            wen_q      <= wen_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
`ifdef RISCV_MEMARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign o_riscv_memarb_mem_req   = (state_q == IF_BUSY) || (state_q == DM_BUSY);
    assign o_riscv_memarb_mem_wen   = wen_q;
    assign o_riscv_memarb_mem_sel   = sel_q;
    assign o_riscv_memarb_mem_addr  = addr_q;
    assign o_riscv_memarb_mem_wdata = wdata_q;

    // Grant is exclusive, so the two valids can never coincide.
    assign o_riscv_memarb_if_valid = (state_q == RESP) & ~grant_dm_q & live_q & i_riscv_memarb_if_req;
    assign o_riscv_memarb_dm_valid = (state_q == RESP) &  grant_dm_q & live_q & i_riscv_memarb_dm_req;

    assign o_riscv_memarb_if_inst  = addr_q[2] ? rdata_q[63:32] : rdata_q[31:0];
    assign o_riscv_memarb_dm_rdata = rdata_q;

    // Gated by reset so stalls drop the instant reset asserts.
    assign o_riscv_memarb_stall_if = i_riscv_memarb_rst & i_riscv_memarb_if_req & ~o_riscv_memarb_if_valid;
    assign o_riscv_memarb_stall_m  = i_riscv_memarb_rst & i_riscv_memarb_dm_req & ~o_riscv_memarb_dm_valid;

endmodule

// File: tb/tb_riscv_memarb.sv
// tb/tb_riscv_memarb.sv - directed self-checking bench for riscv_memarb
module tb_riscv_memarb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [63:0] if_addr;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        dm_req;
    logic        dm_wen;
    logic [1:0]  dm_sel;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic [63:0] dm_rdata;
    logic        dm_valid;
    logic        mem_req;
    logic        mem_wen;
    logic [1:0]  mem_sel;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        stall_if;
    logic        stall_m;

    int n_cmp = 0;
    int n_err = 0;

    riscv_memarb dut (
        .i_riscv_memarb_clk      (clk),
        .i_riscv_memarb_rst      (rst_n),
        .i_riscv_memarb_if_req   (if_req),
        .i_riscv_memarb_if_addr  (if_addr),
        .o_riscv_memarb_if_inst  (if_inst),
        .o_riscv_memarb_if_valid (if_valid),
        .i_riscv_memarb_dm_req   (dm_req),
        .i_riscv_memarb_dm_wen   (dm_wen),
        .i_riscv_memarb_dm_sel   (dm_sel),
        .i_riscv_memarb_dm_addr  (dm_addr),
        .i_riscv_memarb_dm_wdata (dm_wdata),
        .o_riscv_memarb_dm_rdata (dm_rdata),
        .o_riscv_memarb_dm_valid (dm_valid),
        .o_riscv_memarb_mem_req  (mem_req),
        .o_riscv_memarb_mem_wen  (mem_wen),
        .o_riscv_memarb_mem_sel  (mem_sel),
        .o_riscv_memarb_mem_addr (mem_addr),
        .o_riscv_memarb_mem_wdata(mem_wdata),
        .i_riscv_memarb_mem_ack  (mem_ack),
        .i_riscv_memarb_mem_rdata(mem_rdata),
        .o_riscv_memarb_stall_if (stall_if),
        .o_riscv_memarb_stall_m  (stall_m)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    logic [63:0] exp_addr;
    logic        exp_ifv;
    logic        exp_dmv;

    initial begin
        rst_n = 1'b0; if_req = 0; if_addr = 0; dm_req = 0; dm_wen = 0; dm_sel = 0;
        dm_addr = 0; dm_wdata = 0; mem_ack = 0; mem_rdata = 0;
        nxt(); nxt();
        smp();
        check("rst_mem_req", mem_req, 0);
        check("rst_if_valid", if_valid, 0);
        check("rst_dm_valid", dm_valid, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_dm_rdata", dm_rdata, 0);
        nxt(); rst_n = 1'b1;

        // Fetch only, zero-wait ack
        nxt(); if_req = 1; if_addr = 64'h104;
        smp();
        check("f_c0_stall_if", stall_if, 1);
        check("f_c0_mem_req", mem_req, 0);
        nxt(); mem_ack = 1; mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        smp();
        check("f_c1_mem_req", mem_req, 1);
        check("f_c1_mem_addr", mem_addr, 64'h104);
        check("f_c1_mem_wen", mem_wen, 0);
        check("f_c1_mem_sel", mem_sel, 2'b11);
        check("f_c1_stall_if", stall_if, 1);
        nxt(); mem_ack = 0;
        smp();
        check("f_c2_if_valid", if_valid, 1);
        check("f_c2_if_inst", if_inst, 32'hAAAA_BBBB);
        check("f_c2_stall_if", stall_if, 0);
        check("f_c2_mem_req", mem_req, 0);
        nxt(); if_req = 0;
        smp();
        check("f_c3_if_valid", if_valid, 0);
        check("f_c3_mem_req", mem_req, 0);

        // Both pending: data first, then fetch
        nxt(); dm_req = 1; dm_wen = 1; dm_sel = 2'b10; dm_addr = 64'h2000; dm_wdata = 64'h1234;
        if_req = 1; if_addr = 64'h108;
        smp();
        check("b_c0_stall_m", stall_m, 1);
        nxt(); mem_ack = 1; mem_rdata = 64'h0;
        smp();
        check("b_c1_mem_wen", mem_wen, 1);
        check("b_c1_mem_sel", mem_sel, 2'b10);
        check("b_c1_mem_addr", mem_addr, 64'h2000);
        check("b_c1_mem_wdata", mem_wdata, 64'h1234);
        nxt(); mem_ack = 0;
        smp();
        check("b_c2_dm_valid", dm_valid, 1);
        check("b_c2_if_valid", if_valid, 0);
        check("b_c2_stall_m", stall_m, 0);
        check("b_c2_stall_if", stall_if, 1);
        nxt(); dm_req = 0; dm_wen = 0;
        smp();
        check("b_c3_mem_req", mem_req, 0);
        nxt(); mem_ack = 1; mem_rdata = 64'h1111_2222_3333_4444;
        smp();
        check("b_c4_mem_addr", mem_addr, 64'h108);
        check("b_c4_mem_wen", mem_wen, 0);
        check("b_c4_mem_sel", mem_sel, 2'b11);
        nxt(); mem_ack = 0;
        smp();
        check("b_c5_if_valid", if_valid, 1);
        check("b_c5_if_inst", if_inst, 32'h3333_4444);
        nxt(); if_req = 0;

        // Both pending twice in a row: RR hands the second grant to fetch
        nxt(); dm_req = 1; dm_wen = 0; dm_sel = 2'b11; dm_addr = 64'h3000;
        if_req = 1; if_addr = 64'h10C;
        nxt(); mem_ack = 1; mem_rdata = 64'h0;
        smp();
        check("r_c1_mem_addr", mem_addr, 64'h3000);
        nxt(); mem_ack = 0;
        smp();
        check("r_c2_dm_valid", dm_valid, 1);
        nxt(); dm_addr = 64'h3008;
        nxt(); mem_ack = 1; mem_rdata = 64'h5555_6666_7777_8888;
`ifdef RISCV_MEMARB_RR_EN
        exp_addr = 64'h10C; exp_ifv = 1'b1; exp_dmv = 1'b0;
`else
        exp_addr = 64'h3008; exp_ifv = 1'b0; exp_dmv = 1'b1;
`endif
        smp();
        check("r_c4_mem_addr", mem_addr, exp_addr);
        nxt(); mem_ack = 0;
        smp();
        check("r_c5_if_valid", if_valid, exp_ifv);
        check("r_c5_dm_valid", dm_valid, exp_dmv);
        nxt(); dm_req = 0; if_req = 0;
        smp();
        check("r_c6_mem_req", mem_req, 0);

        // Load with ack after 4 busy cycles
        nxt(); dm_req = 1; dm_wen = 0; dm_sel = 2'b11; dm_addr = 64'h4010; dm_wdata = 64'h0;
        for (int i = 1; i <= 4; i++) begin
            nxt();
            if (i == 4) begin
                mem_ack = 1; mem_rdata = 64'hDEAD_BEEF_0123_4567;
            end
            smp();
            check($sformatf("l_c%0d_mem_req", i), mem_req, 1);
            check($sformatf("l_c%0d_mem_addr", i), mem_addr, 64'h4010);
            check($sformatf("l_c%0d_mem_wen", i), mem_wen, 0);
            check($sformatf("l_c%0d_stall_m", i), stall_m, 1);
            check($sformatf("l_c%0d_dm_valid", i), dm_valid, 0);
        end
        nxt(); mem_ack = 0;
        smp();
        check("l_c5_dm_valid", dm_valid, 1);
        check("l_c5_dm_rdata", dm_rdata, 64'hDEAD_BEEF_0123_4567);
        check("l_c5_stall_m", stall_m, 0);
        nxt(); dm_req = 0;
        smp();
        check("l_c6_dm_valid", dm_valid, 0);

        // Fetch withdrawn after grant
        nxt(); if_req = 1; if_addr = 64'h200;
        nxt(); if_req = 0;
        smp();
        check("w_c1_mem_req", mem_req, 1);
        nxt(); mem_ack = 1; mem_rdata = 64'h9999_8888_7777_6666;
        smp();
        check("w_c2_mem_req", mem_req, 1);
        nxt(); mem_ack = 0;
        smp();
        check("w_c3_if_valid", if_valid, 0);
        check("w_c3_mem_req", mem_req, 0);
        nxt();
        smp();
        check("w_c4_mem_req", mem_req, 0);
        check("w_c4_if_valid", if_valid, 0);

        // Reset in DM_BUSY, then a clean fetch
        nxt(); dm_req = 1; dm_wen = 1; dm_sel = 2'b01; dm_addr = 64'h5000; dm_wdata = 64'hFF;
        if_req = 1; if_addr = 64'h300;
        nxt();
        smp();
        check("x_busy_mem_req", mem_req, 1);
        #1 rst_n = 1'b0;
        #1;
        check("x_rst_mem_req", mem_req, 0);
        check("x_rst_dm_valid", dm_valid, 0);
        check("x_rst_if_valid", if_valid, 0);
        check("x_rst_stall_m", stall_m, 0);
        check("x_rst_stall_if", stall_if, 0);
        check("x_rst_mem_wen", mem_wen, 0);
        dm_req = 0; dm_wen = 0; if_req = 0;
        nxt(); rst_n = 1'b1;
        nxt(); if_req = 1;
        smp();
        check("x_f0_mem_req", mem_req, 0);
        nxt(); mem_ack = 1; mem_rdata = 64'h0BAD_F00D_1357_9BDF;
        smp();
        check("x_f1_mem_addr", mem_addr, 64'h300);
        check("x_f1_mem_wen", mem_wen, 0);
        nxt(); mem_ack = 0;
        smp();
        check("x_f2_if_valid", if_valid, 1);
        check("x_f2_if_inst", if_inst, 32'h1357_9BDF);
        nxt(); if_req = 0;

        // Spurious ack while idle
        nxt(); mem_ack = 1; mem_rdata = 64'h1;
        smp();
        check("a_c0_mem_req", mem_req, 0);
        nxt(); mem_ack = 0;
        smp();
        check("a_c1_if_valid", if_valid, 0);
        check("a_c1_dm_valid", dm_valid, 0);
        check("a_c1_mem_req", mem_req, 0);
        nxt(); dm_req = 1; dm_wen = 0; dm_addr = 64'h6000;
        nxt();
        smp();
        check("a_c3_mem_req", mem_req, 1);
        check("a_c3_mem_addr", mem_addr, 64'h6000);
        mem_ack = 1; mem_rdata = 64'h42;
        nxt(); mem_ack = 0;
        smp();
        check("a_c4_dm_valid", dm_valid, 1);
        check("a_c4_dm_rdata", dm_rdata, 64'h42);
        nxt(); dm_req = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_memarb.md
Name: riscv_memarb

Overview:
- Arbitrates one shared single-port memory between instruction fetch (read-only, 32-bit) and the MEM-stage data access (read/write, 64-bit).
- Replaces the separate IM/DM instances at the core top level.
- Sequences the memory's variable-latency req/ack handshake.
- Drives per-stage stall outputs into the hazard unit.

Parameters:
- ADDR_W, 64, address width of all ports.
- DATA_W, 64, memory data width; the instruction is a 32-bit slice of it.

Ports:
- i_riscv_memarb_clk  in  1  core clock
- i_riscv_memarb_rst  in  1  asynchronous, active-low reset
- i_riscv_memarb_if_req  in  1  fetch request; level, held until if_valid
- i_riscv_memarb_if_addr  in  ADDR_W  fetch address, 4-byte aligned
- o_riscv_memarb_if_inst  out  32  fetched instruction
- o_riscv_memarb_if_valid  out  1  one-cycle pulse: if_inst valid
- i_riscv_memarb_dm_req  in  1  data request; level, held until dm_valid
- i_riscv_memarb_dm_wen  in  1  1 = store, 0 = load
- i_riscv_memarb_dm_sel  in  2  store size: 00 = B, 01 = H, 10 = W, 11 = D
- i_riscv_memarb_dm_addr  in  ADDR_W  data address
- i_riscv_memarb_dm_wdata  in  DATA_W  store data
- o_riscv_memarb_dm_rdata  out  DATA_W  load data
- o_riscv_memarb_dm_valid  out  1  one-cycle pulse: access complete
- o_riscv_memarb_mem_req  out  1  memory request
- o_riscv_memarb_mem_wen  out  1  memory write enable
- o_riscv_memarb_mem_sel  out  2  memory store size
- o_riscv_memarb_mem_addr  out  ADDR_W  memory address
- o_riscv_memarb_mem_wdata  out  DATA_W  memory write data
- i_riscv_memarb_mem_ack  in  1  memory completion; read data valid same cycle
- i_riscv_memarb_mem_rdata  in  DATA_W  memory read data
- o_riscv_memarb_stall_if  out  1  to hazard unit: stall PC and F/D
- o_riscv_memarb_stall_m  out  1  to hazard unit: stall whole pipe for MEM access

Behaviour:
- Reset: all outputs 0; FSM = IDLE; latched grant/data registers cleared. Reset is asynchronous and may occur mid-transaction; mem_req drops immediately and the memory must abandon the access.
- FSM states: IDLE, IF_BUSY, DM_BUSY, RESP.
- IDLE:
  - if dm_req -> DM_BUSY; else if if_req -> IF_BUSY.
  - Fixed data priority; the MEM-stage instruction is older than the fetch.
  - On the transition, latch wen/sel/addr/wdata from the winner (fetch: wen = 0, sel = 11).
- IF_BUSY / DM_BUSY:
  - mem_req = 1, all mem_* fields driven from registers and stable until ack.
  - On ack: capture rdata, -> RESP.
  - No timeout; the state waits indefinitely.
- RESP:
  - Pulse if_valid or dm_valid for 1 cycle according to the grant.
  - if_inst = if_addr[2] ? rdata[63:32] : rdata[31:0], using the latched address.
  - dm_rdata = full 64-bit word; the datapath performs extension.
  - Next state is IDLE. A request still high in IDLE is treated as new, since the requester updates its address on the valid cycle.
- Minimum latency:
  - cycle 0: req
  - cycle 1: mem_req, zero-wait ack
  - cycle 2: valid
  - Throughput is 1 access per 3 cycles.
- Stalls (combinational):
  - stall_if = if_req & ~if_valid.
  - stall_m = dm_req & ~dm_valid.
  - stall_m has precedence in the hazard unit.
- Request withdrawn while its access is in flight (branch flush of fetch):
  - The memory transaction completes normally.
  - RESP suppresses the valid pulse for that requester.
  - A store in flight is never cancelled.
- ack while in IDLE or RESP: ignored.
- if_valid and dm_valid are never high in the same cycle.

Optional Feature:
- Macro: RISCV_MEMARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit last_grant register (reset = fetch) is maintained.
  - When both requests are pending in IDLE, the requester not granted last wins.
  - A single pending request is always served.
- Undefined: fixed data-over-fetch priority; no last_grant register.

Test Plan:
- Fetch only, addr 0x104, zero-wait ack, rdata 0xAAAA_BBBB_CCCC_DDDD -> mem_req cycle 1 with addr 0x104, wen 0; if_valid cycle 2 with if_inst 0xAAAA_BBBB; stall_if high cycles 0-1.
- dm_req and if_req both high in cycle 0 (store, sel 10, addr 0x2000, wdata 0x1234) -> data served first (mem_wen 1, sel 10); fetch granted at the next IDLE; if_valid 3 cycles after dm_valid. With RISCV_MEMARB_RR_EN, a repeated both-pending case grants fetch.
- Load with ack delayed 4 cycles -> mem_* fields stable all 4 cycles; dm_valid exactly 1 cycle after ack; stall_m continuous until dm_valid.
- if_req dropped in the cycle after grant -> memory access completes; no if_valid pulse; FSM back to IDLE.
- Reset asserted low while in DM_BUSY -> mem_req, all valids and stalls 0 immediately; after release, FSM in IDLE and a new fetch completes normally.
- ack pulsed while idle with no requests -> no valid pulse, no state change.
